rv32_retire_trace: RTL and testbench

- Commit-trace buffer directly downstream of the RV32 core's write-back stage.
- Consumes the per-cycle retirement record: valid, pc, imm, rs1n, rs2n, rdn, RegWrite, Exception.
- Stamps each record with a sequence number and buffers it in a FIFO. A debug host or testbench drains the FIFO over a valid/ready handshake.
- Detects the exception record, captures it exactly once, and reports halt once the trace has fully drained.

---
 rtl/rv32_retire_trace.sv | 132 +++++++++++++
 tb/tb_rv32_retire_trace.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_retire_trace.sv
// Commit-trace buffer behind the RV32 write-back stage: stamps retired records with a
// sequence number, queues them in a fall-through FIFO and halts once an exception drains.
module rv32_retire_trace #(
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [31:0]   in_pc,
   input  logic [31:0]   in_imm,
   input  logic [4:0]    in_rs1n,
   input  logic [4:0]    in_rs2n,
   input  logic [4:0]    in_rdn,
   input  logic          in_regwrite,
   input  logic          in_exception,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [31:0]   out_pc,
   output logic [31:0]   out_imm,
   output logic [4:0]    out_rs1n,
   output logic [4:0]    out_rs2n,
   output logic [4:0]    out_rdn,
   output logic          out_regwrite,
   output logic          out_exception,
   output logic [31:0]   out_seq,
   output logic [AW:0]   level,
   output logic [15:0]   overflow_cnt,
   output logic          halted,
   output logic [1:0]    dbg_state
);

   // Handshake: a record leaves the head on any rising edge where out_valid & out_ready;
   // out_valid never depends on out_ready, and the head stays stable until popped.

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      STOP   = 2'd1,
      HALTED = 2'd2
   } state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] imm;
      logic [4:0]  rs1n;
      logic [4:0]  rs2n;
      logic [4:0]  rdn;
      logic        regwrite;
      logic        exception;
      logic [31:0] seq;
   } entry_t;

   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   state_t        state, state_nxt;
   entry_t        mem [DEPTH];
   entry_t        head;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [31:0]   seq_cnt;

   logic pop, attempt, can_accept, push, exc_wait, drop, seq_inc;

   always_comb begin
      pop        = 1'b0;
      attempt    = 1'b0;
      can_accept = 1'b0;
      push       = 1'b0;
      exc_wait   = 1'b0;
      drop       = 1'b0;
      seq_inc    = 1'b0;
      state_nxt  = state;

      pop        = out_valid & out_ready;
      attempt    = (state == RUN) & in_valid;
      // A full FIFO still has room when the head leaves on the same edge.
      can_accept = (level != FULL_LVL) | pop;
      push       = attempt & can_accept;
      // A blocked exception record is retried next cycle rather than dropped.
      exc_wait   = attempt & in_exception & ~can_accept;
      drop       = attempt & ~in_exception & ~can_accept;
      seq_inc    = attempt & ~exc_wait;

      case (state)
         RUN:     if (push && in_exception) state_nxt = STOP;
         STOP:    if (level == '0) state_nxt = HALTED;
         HALTED:  state_nxt = HALTED;
         default: state_nxt = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= RUN;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         level        <= '0;
         seq_cnt      <= '0;
         overflow_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      level <= level + 1'b1;
         else if (pop && !push) level <= level - 1'b1;
         if (seq_inc) seq_cnt <= seq_cnt + 32'd1;
         if (drop && overflow_cnt != 16'hFFFF) overflow_cnt <= overflow_cnt + 16'd1;
      end
   end

   // Storage carries no reset; the read side is masked while empty.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= '{pc: in_pc, imm: in_imm, rs1n: in_rs1n, rs2n: in_rs2n,
                          rdn: in_rdn, regwrite: in_regwrite,
                          exception: in_exception, seq: seq_cnt};
      end
   end

   assign out_valid     = (level != '0);
   assign head          = out_valid ? mem[rd_ptr] : '0;
   assign out_pc        = head.pc;
   assign out_imm       = head.imm;
   assign out_rs1n      = head.rs1n;
   assign out_rs2n      = head.rs2n;
   assign out_rdn       = head.rdn;
   assign out_regwrite  = head.regwrite;
   assign out_exception = head.exception;
   assign out_seq       = head.seq;
   assign halted        = (state == HALTED);
   assign dbg_state     = state;

endmodule

// File: tb/tb_rv32_retire_trace.sv
// Directed bench for rv32_retire_trace: a per-cycle vector table for ordering plus
// hand-written sequences for overflow, full push/pop, exception halt and async reset.
module tb_rv32_retire_trace;

   localparam int DEPTH = 16;
   localparam int AW    = 4;
   localparam int W     = 65;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_pc = '0;
   logic [31:0] in_imm = '0;
   logic [4:0]  in_rs1n = '0, in_rs2n = '0, in_rdn = '0;
   logic        in_regwrite = 1'b0, in_exception = 1'b0;
   logic        out_valid, out_ready = 1'b0;
   logic [31:0] out_pc, out_imm, out_seq;
   logic [4:0]  out_rs1n, out_rs2n, out_rdn;
   logic        out_regwrite, out_exception;
   logic [AW:0] level;
   logic [15:0] overflow_cnt;
   logic        halted;
   logic [1:0]  dbg_state;

   int n_tests = 0;
   int n_fail  = 0;

   // Expected queue entries: {exception, pc, seq}
   logic [W-1:0] exp_q[$];

   typedef struct {
      logic        in_valid;
      logic [31:0] in_pc;
      logic        in_ready;
      logic        exp_valid;
      logic [31:0] exp_pc;
      logic [31:0] exp_seq;
      logic [4:0]  exp_level;
   } vec_t;

   vec_t vecs[9];

   rv32_retire_trace #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_pc(in_pc), .in_imm(in_imm),
      .in_rs1n(in_rs1n), .in_rs2n(in_rs2n), .in_rdn(in_rdn),
      .in_regwrite(in_regwrite), .in_exception(in_exception),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_imm(out_imm),
      .out_rs1n(out_rs1n), .out_rs2n(out_rs2n), .out_rdn(out_rdn),
      .out_regwrite(out_regwrite), .out_exception(out_exception),
      .out_seq(out_seq), .level(level), .overflow_cnt(overflow_cnt),
      .halted(halted), .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   task automatic do_reset();
      in_valid  = 1'b0;
      in_exception = 1'b0;
      out_ready = 1'b0;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      exp_q.delete();
   endtask

   // ---------------- drivers ----------------
   // Side fields are derived from pc so the bench can predict them for any entry.
   task automatic drive(input logic v, input logic [31:0] pc, input logic exc, input logic rdy);
      in_valid     = v;
      in_pc        = pc;
      in_imm       = ~pc;
      in_rs1n      = pc[6:2];
      in_rs2n      = pc[6:2] + 5'd1;
      in_rdn       = pc[6:2] + 5'd2;
      in_regwrite  = pc[2];
      in_exception = exc;
      out_ready    = rdy;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic fill(input logic [31:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         drive(1'b1, base + 32'(4 * i), 1'b0, 1'b0);
         step();
      end
      in_valid = 1'b0;
   endtask

   // ---------------- scoreboard ----------------
   task automatic drain(input string name);
      logic [W-1:0] e;
      for (int k = 0; k < 64 && exp_q.size() > 0; k++) begin
         e = exp_q.pop_front();
         chk({name, "_valid"}, 32'(out_valid), 32'd1);
         chk({name, "_pc"},    out_pc, e[63:32]);
         chk({name, "_seq"},   out_seq, e[31:0]);
         chk({name, "_exc"},   32'(out_exception), 32'(e[64]));
         chk({name, "_imm"},   out_imm, ~e[63:32]);
         chk({name, "_rdn"},   32'(out_rdn), 32'(e[38:34] + 5'd2));
         drive(1'b0, 32'h0, 1'b0, 1'b1);
         step();
      end
      out_ready = 1'b0;
      chk({name, "_empty"}, 32'(level), 32'd0);
   endtask

   // ---------------- test ----------------
   initial begin
      vecs[0] = '{1'b1, 32'h00, 1'b1, 1'b1, 32'h00, 32'd0, 5'd1};
      vecs[1] = '{1'b1, 32'h04, 1'b1, 1'b1, 32'h04, 32'd1, 5'd1};
      vecs[2] = '{1'b1, 32'h08, 1'b1, 1'b1, 32'h08, 32'd2, 5'd1};
      vecs[3] = '{1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 32'd0, 5'd0};
      vecs[4] = '{1'b1, 32'h20, 1'b0, 1'b1, 32'h20, 32'd3, 5'd1};
      vecs[5] = '{1'b1, 32'h24, 1'b0, 1'b1, 32'h20, 32'd3, 5'd2};
      vecs[6] = '{1'b0, 32'h00, 1'b1, 1'b1, 32'h24, 32'd4, 5'd1};
      vecs[7] = '{1'b1, 32'h28, 1'b1, 1'b1, 32'h28, 32'd5, 5'd1};
      vecs[8] = '{1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 32'd0, 5'd0};

      // Reset state
      do_reset();
      chk("rst_valid",  32'(out_valid), 32'd0);
      chk("rst_level",  32'(level), 32'd0);
      chk("rst_ovf",    32'(overflow_cnt), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_state",  32'(dbg_state), 32'd0);
      chk("rst_pc",     out_pc, 32'd0);
      chk("rst_seq",    out_seq, 32'd0);

      // Basic ordering, one row per clock edge
      for (int i = 0; i < 9; i++) begin
         drive(vecs[i].in_valid, vecs[i].in_pc, 1'b0, vecs[i].in_ready);
         step();
         chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
         chk($sformatf("vec%0d_pc", i),    out_pc, vecs[i].exp_pc);
         chk($sformatf("vec%0d_seq", i),   out_seq, vecs[i].exp_seq);
         chk($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].exp_level));
         chk($sformatf("vec%0d_imm", i),   out_imm, vecs[i].exp_valid ? ~vecs[i].exp_pc : 32'h0);
         chk($sformatf("vec%0d_ovf", i),   32'(overflow_cnt), 32'd0);
      end

      // Overflow: 20 records into a 16-deep FIFO
      do_reset();
      fill(32'h0, 20);
      for (int i = 0; i < DEPTH; i++) exp_q.push_back({1'b0, 32'(4 * i), 32'(i)});
      chk("ovf_level", 32'(level), 32'd16);
      chk("ovf_cnt",   32'(overflow_cnt), 32'd4);
      drain("ovf_drain");

      // Push and pop on the same edge while full
      do_reset();
      fill(32'h100, 16);
      for (int i = 0; i < DEPTH; i++) exp_q.push_back({1'b0, 32'h100 + 32'(4 * i), 32'(i)});
      chk("pp_head_before", out_pc, 32'h100);
      drive(1'b1, 32'h200, 1'b0, 1'b1);
      step();
      void'(exp_q.pop_front());
      exp_q.push_back({1'b0, 32'h200, 32'd16});
      in_valid = 1'b0;
      out_ready = 1'b0;
      chk("pp_level", 32'(level), 32'd16);
      chk("pp_ovf",   32'(overflow_cnt), 32'd0);
      chk("pp_head",  out_pc, 32'h104);
      chk("pp_seq",   out_seq, 32'd1);
      drain("pp_drain");

      // Exception capture and halt
      do_reset();
      drive(1'b1, 32'h10, 1'b0, 1'b1);
      step();
      chk("exc_h0_pc",  out_pc, 32'h10);
      chk("exc_h0_exc", 32'(out_exception), 32'd0);
      for (int c = 0; c < 10; c++) begin
         drive(1'b1, 32'h14, 1'b1, 1'b1);
         step();
         if (c == 0) begin
            chk("exc_cap_pc",    out_pc, 32'h14);
            chk("exc_cap_seq",   out_seq, 32'd1);
            chk("exc_cap_exc",   32'(out_exception), 32'd1);
            chk("exc_cap_state", 32'(dbg_state), 32'd1);
         end else if (c == 1) begin
            chk("exc_empty_level",  32'(level), 32'd0);
            chk("exc_empty_halted", 32'(halted), 32'd0);
         end else begin
            chk($sformatf("exc_hold%0d_halted", c), 32'(halted), 32'd1);
            chk($sformatf("exc_hold%0d_valid", c),  32'(out_valid), 32'd0);
            chk($sformatf("exc_hold%0d_ovf", c),    32'(overflow_cnt), 32'd0);
         end
      end
      drive(1'b1, 32'h18, 1'b0, 1'b1);
      step();
      chk("halt_ignore_valid", 32'(out_valid), 32'd0);
      chk("halt_state",        32'(dbg_state), 32'd2);
      in_valid = 1'b0;

      // Exception arriving while full
      do_reset();
      fill(32'h300, 16);
      for (int i = 0; i < DEPTH; i++) exp_q.push_back({1'b0, 32'h300 + 32'(4 * i), 32'(i)});
      exp_q.push_back({1'b1, 32'h400, 32'd16});
      for (int c = 0; c < 5; c++) begin
         drive(1'b1, 32'h400, 1'b1, 1'b0);
         step();
         chk($sformatf("xf_wait%0d_ovf", c),   32'(overflow_cnt), 32'd0);
         chk($sformatf("xf_wait%0d_level", c), 32'(level), 32'd16);
         chk($sformatf("xf_wait%0d_state", c), 32'(dbg_state), 32'd0);
      end
      chk("xf_head_before", out_pc, 32'h300);
      drive(1'b1, 32'h400, 1'b1, 1'b1);
      step();
      void'(exp_q.pop_front());
      in_valid = 1'b0;
      out_ready = 1'b0;
      chk("xf_cap_level", 32'(level), 32'd16);
      chk("xf_cap_state", 32'(dbg_state), 32'd1);
      chk("xf_cap_ovf",   32'(overflow_cnt), 32'd0);
      drain("xf_drain");
      chk("xf_pre_halt", 32'(halted), 32'd0);
      step();
      chk("xf_halted",   32'(halted), 32'd1);

      // Async reset mid-stream
      do_reset();
      fill(32'h600, 18);
      for (int i = 0; i < 11; i++) begin
         drive(1'b0, 32'h0, 1'b0, 1'b1);
         step();
      end
      out_ready = 1'b0;
      chk("ar_pre_level", 32'(level), 32'd5);
      chk("ar_pre_ovf",   32'(overflow_cnt), 32'd2);
      #3 rst = 1'b0;
      #1;
      chk("ar_level",  32'(level), 32'd0);
      chk("ar_valid",  32'(out_valid), 32'd0);
      chk("ar_ovf",    32'(overflow_cnt), 32'd0);
      chk("ar_halted", 32'(halted), 32'd0);
      chk("ar_pc",     out_pc, 32'd0);
      #1 rst = 1'b1;
      step();
      drive(1'b1, 32'h500, 1'b0, 1'b0);
      step();
      in_valid = 1'b0;
      chk("ar_next_pc",  out_pc, 32'h500);
      chk("ar_next_seq", out_seq, 32'd0);
      chk("ar_next_lvl", 32'(level), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
